// File: rtl/per_uart_fifo.sv
// per_uart_fifo: full-duplex 8N1 UART with TX/RX FIFOs, runtime baud divisor, sticky errors and maskable irq
module per_uart_fifo #(
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int DIV_WIDTH = 16,
  parameter int DIV_RESET = 434
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic [1:0]  size_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        irq_o
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [DIV_WIDTH-1:0] baud, div_eff, tx_div, tx_ctr, rx_div, rx_ctr;
  logic ovr, ferr, ien_rx, ien_tx;
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wr, tx_rd;
  logic [RAW-1:0] rx_wr, rx_rd;
  logic [TCW-1:0] tx_cnt;
  logic [RCW-1:0] rx_cnt;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
  logic wr_csr, wr_data, wr_baud, rd_data, tx_tc, rx_tc, rx_half, stop_smp, set_ovr, set_ferr, tx_idle;
  state_t tx_st, rx_st;
  logic [7:0] tx_sh, rx_sh;
  logic [2:0] tx_bit, rx_bit;
  logic rx_s1, rx_s2, rx_prev;
  logic [31:0] csr;
  logic unused;
  assign unused   = ^{size_i, wdata_i};
  assign wr_csr   = wr_i && addr_i == 16'h0000;
  assign wr_data  = wr_i && addr_i == 16'h0004;
  assign wr_baud  = wr_i && addr_i == 16'h0008;
  assign rd_data  = rd_i && addr_i == 16'h0004;
  assign div_eff  = baud < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : baud;
  assign tx_full  = tx_cnt == TCW'(TX_DEPTH);
  assign tx_empty = tx_cnt == '0;
  assign rx_full  = rx_cnt == RCW'(RX_DEPTH);
  assign rx_empty = rx_cnt == '0;
  assign tx_tc    = tx_ctr == tx_div;
  assign rx_tc    = rx_ctr == rx_div;
  assign rx_half  = rx_ctr == (rx_div >> 1);
  assign tx_push  = wr_data && !tx_full;
  assign tx_pop   = !tx_empty && (tx_st == IDLE || (tx_st == STOP && tx_tc));
  assign rx_pop   = rd_data && !rx_empty;
  assign stop_smp = rx_st == STOP && rx_tc;
  assign rx_push  = stop_smp && rx_s2 && !rx_full;
  assign set_ovr  = stop_smp && rx_s2 && rx_full;
  assign set_ferr = stop_smp && !rx_s2;
  assign tx_idle  = tx_empty && tx_st == IDLE;
  assign csr      = {22'h0, ien_tx, ien_rx, 3'b000, ferr, ovr, tx_idle, !rx_empty, !tx_full};
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      tx_wr  <= tx_push ? tx_wr + TAW'(1) : tx_wr;
      tx_rd  <= tx_pop ? tx_rd + TAW'(1) : tx_rd;
      tx_cnt <= tx_cnt + TCW'(tx_push) - TCW'(tx_pop);
      rx_wr  <= rx_push ? rx_wr + RAW'(1) : rx_wr;
      rx_rd  <= rx_pop ? rx_rd + RAW'(1) : rx_rd;
      rx_cnt <= rx_cnt + RCW'(rx_push) - RCW'(rx_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr] <= wdata_i[7:0];
    if (rx_push) rx_mem[rx_wr] <= rx_sh;
  end
  // tx_pop doubles as the frame loader, so a frame queued at the end of STOP starts with no gap
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_st     <= IDLE;
      tx_ctr    <= '0;
      tx_div    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      tx_ctr <= (tx_st == IDLE || tx_tc) ? '0 : tx_ctr + DIV_WIDTH'(1);
      if (tx_pop) begin
        tx_st     <= START;
        tx_sh     <= tx_mem[tx_rd];
        tx_div    <= div_eff;
        uart_tx_o <= 1'b0;
      end else if (tx_tc) begin
        case (tx_st)
          START: begin
            tx_st     <= DATA;
            tx_bit    <= '0;
            uart_tx_o <= tx_sh[0];
          end
          DATA: begin
            tx_st     <= tx_bit == 3'd7 ? STOP : DATA;
            uart_tx_o <= tx_bit == 3'd7 ? 1'b1 : tx_sh[1];
            tx_sh     <= tx_sh >> 1;
            tx_bit    <= tx_bit + 3'd1;
          end
          STOP:    tx_st <= IDLE;
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= IDLE;
      rx_ctr  <= '0;
      rx_div  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_s1   <= uart_rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_ctr  <= (rx_st == IDLE || rx_tc || (rx_st == START && rx_half)) ? '0 : rx_ctr + DIV_WIDTH'(1);
      case (rx_st)
        IDLE: if (rx_prev && !rx_s2) begin
          rx_st  <= START;
          rx_div <= div_eff;
        end
        START: if (rx_half) begin
          rx_st  <= rx_s2 ? IDLE : DATA;
          rx_bit <= '0;
        end
        DATA: if (rx_tc) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          rx_st  <= rx_bit == 3'd7 ? STOP : DATA;
        end
        STOP: if (rx_tc) rx_st <= IDLE;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      baud    <= DIV_WIDTH'(DIV_RESET);
      ien_rx  <= 1'b0;
      ien_tx  <= 1'b0;
      ovr     <= 1'b0;
      ferr    <= 1'b0;
      irq_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      if (wr_baud) baud <= wdata_i[DIV_WIDTH-1:0];
      if (wr_csr) {ien_tx, ien_rx} <= wdata_i[9:8];
      ovr   <= set_ovr | (ovr & !(wr_csr & wdata_i[3]));
      ferr  <= set_ferr | (ferr & !(wr_csr & wdata_i[4]));
      irq_o <= (ien_rx & !rx_empty) | (ien_tx & tx_empty) | ovr | ferr;
      if (rd_i)
        rdata_o <= addr_i == 16'h0000 ? csr :
                   addr_i == 16'h0004 ? {24'h0, rx_empty ? 8'h00 : rx_mem[rx_rd]} :
                   addr_i == 16'h0008 ? 32'(baud) : 32'h0;
    end
  end
endmodule

// File: tb/tb_per_uart_fifo.sv
// tb_per_uart_fifo: randomized self-checking bench for per_uart_fifo against a frame/queue model
module tb_per_uart_fifo;
  localparam int TXD = 4;
  localparam int RXD = 2;
  logic clk = 1'b0, reset = 1'b1, rd = 1'b0, wr = 1'b0, rx = 1'b1, tx, irq;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [1:0] size = 2'b10;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  per_uart_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk_i(clk), .reset_i(reset), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .size_i(size),
    .rd_i(rd), .wr_i(wr), .uart_rx_i(rx), .uart_tx_o(tx), .irq_o(irq));
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask
  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      tick(div + 1);
    end
    rx = 1'b1;
    tick(2 * (div + 1));
  endtask
  // Expected line: each frame is start 0, 8 data bits LSB first, stop 1, every bit div+1 clocks, frames abutted
  task automatic check_frames(input logic [7:0] b[8], input int n, input int div, input string name);
    int w = 0;
    bit bad;
    while (tx === 1'b1 && w < 200) begin tick(); w++; end
    tests++;
    if (tx !== 1'b0) begin
      fails++;
      $display("FAIL %s start: uart_tx_o=%b expected 0 within 200 cycles", name, tx);
      return;
    end
    for (int k = 0; k < n; k++) begin
      logic [9:0] f;
      f = {1'b1, b[k], 1'b0};
      bad = 0;
      for (int i = 0; i < 10 * (div + 1); i++) begin
        if (!bad && tx !== f[i / (div + 1)]) begin
          bad = 1;
          $display("FAIL %s frame %0d cycle %0d: uart_tx_o=%b expected %b", name, k, i, tx, f[i / (div + 1)]);
        end
        if (!(k == n - 1 && i == 10 * (div + 1) - 1)) tick();
      end
      tests++;
      if (bad) fails++;
    end
  endtask
  // Pushes nw bytes on consecutive cycles; the first leaves the FIFO at once, so TXD+1 can be accepted
  task automatic run_tx(input logic [7:0] b[8], input int nw, input int div, input string name);
    logic [31:0] d;
    int ne;
    ne = nw < TXD + 1 ? nw : TXD + 1;
    fork
      begin for (int i = 0; i < nw; i++) bus_write(16'h0004, {24'h0, b[i]}); end
      check_frames(b, ne, div, name);
    join
    bus_read(16'h0000, d);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL %s busy_at_last_stop: csr=%h expected %h", name, d, 32'h1); end
    bus_read(16'h0000, d);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL %s tx_idle: csr=%h expected %h", name, d, 32'h5); end
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL %s line_idle: uart_tx_o=%b expected 1", name, tx); end
  endtask
  task automatic test_reset;
    logic [31:0] d;
    tests++;
    if (rdata !== 32'h0 || tx !== 1'b1 || irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: rdata=%h tx=%b irq=%b expected 0 1 0", rdata, tx, irq);
    end
    bus_read(16'h0000, d);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL reset_csr: csr=%h expected %h", d, 32'h5); end
    bus_read(16'h0008, d);
    tests++;
    if (d !== 32'd434) begin fails++; $display("FAIL reset_baud: baud=%0d expected 434", d); end
    bus_write(16'h000C, 32'hFFFF_FFFF);
    bus_read(16'h000C, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL unmapped_read: rdata=%h expected 0", d); end
    bus_read(16'h0008, d);
    tests++;
    if (d !== 32'd434) begin fails++; $display("FAIL unmapped_write: baud=%0d expected 434", d); end
  endtask
  task automatic test_tx_back_to_back;
    logic [7:0] b[8];
    b = '{8'h55, 8'hA3, 0, 0, 0, 0, 0, 0};
    bus_write(16'h0008, 32'd3);
    run_tx(b, 2, 3, "tx_b2b");
  endtask
  task automatic test_tx_overflow;
    logic [7:0] b[8];
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    bus_write(16'h0008, 32'd3);
    run_tx(b, 6, 3, "tx_overflow");
  endtask
  task automatic test_tx_random;
    logic [7:0] b[8];
    int div, n;
    for (int r = 0; r < 3; r++) begin
      div = $urandom_range(2, 6);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
      bus_write(16'h0008, 32'(div));
      run_tx(b, n, div, "tx_random");
    end
  endtask
  task automatic test_baud_clamp;
    logic [7:0] b[8];
    logic [31:0] d, v;
    v = 32'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    bus_write(16'h0008, v);
    bus_read(16'h0008, d);
    tests++;
    if (d !== v) begin fails++; $display("FAIL baud_readback: baud=%0d expected %0d", d, v); end
    run_tx(b, 1, 2, "baud_clamp");
  endtask
  task automatic test_rx;
    logic [31:0] d;
    logic [7:0] v;
    bus_write(16'h0008, 32'd3);
    send_rx(8'h3C, 1'b1, 3);
    bus_read(16'h0000, d);
    tests++;
    if (d !== 32'h7) begin fails++; $display("FAIL rx_ready: csr=%h expected %h", d, 32'h7); end
    bus_read(16'h0004, d);
    tests++;
    if (d !== 32'h3C) begin fails++; $display("FAIL rx_data: data=%h expected %h", d, 32'h3C); end
    bus_read(16'h0000, d);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL rx_drained: csr=%h expected %h", d, 32'h5); end
    for (int r = 0; r < 4; r++) begin
      v = 8'($urandom);
      send_rx(v, 1'b1, 3);
      bus_read(16'h0004, d);
      tests++;
      if (d !== {24'h0, v}) begin fails++; $display("FAIL rx_random: data=%h expected %h", d, v); end
    end
    rx = 1'b0;
    tick();
    rx = 1'b1;
    tick(20);
    bus_read(16'h0000, d);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL rx_glitch: csr=%h expected %h", d, 32'h5); end
  endtask
  task automatic test_frame_err;
    logic [31:0] d;
    send_rx(8'($urandom), 1'b0, 3);
    bus_read(16'h0000, d);
    tests++;
    if (d !== 32'h15) begin fails++; $display("FAIL ferr_set: csr=%h expected %h", d, 32'h15); end
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL ferr_irq: irq=%b expected 1", irq); end
    bus_read(16'h0004, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL ferr_discard: data=%h expected 0", d); end
    bus_write(16'h0000, 32'h10);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL ferr_irq_lag: irq=%b expected 1", irq); end
    tick();
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL ferr_irq_clear: irq=%b expected 0", irq); end
    bus_read(16'h0000, d);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL ferr_clear: csr=%h expected %h", d, 32'h5); end
  endtask
  task automatic test_irq_enables;
    logic [31:0] d;
    bus_write(16'h0000, 32'h300);
    tick();
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL irq_tx_en: irq=%b expected 1", irq); end
    bus_read(16'h0000, d);
    tests++;
    if (d !== 32'h305) begin fails++; $display("FAIL irq_en_readback: csr=%h expected %h", d, 32'h305); end
    bus_write(16'h0000, 32'h100);
    tick();
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_rx_en_empty: irq=%b expected 0", irq); end
    send_rx(8'($urandom), 1'b1, 3);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL irq_rx_ready: irq=%b expected 1", irq); end
    bus_read(16'h0004, d);
    tick();
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_rx_drained: irq=%b expected 0", irq); end
    bus_write(16'h0000, 32'h0);
  endtask
  task automatic test_overrun;
    logic [31:0] d, e;
    logic [7:0] q[$];
    logic [7:0] v;
    bit ov = 0;
    for (int i = 0; i < RXD + 1; i++) begin
      v = 8'($urandom);
      send_rx(v, 1'b1, 3);
      if (q.size() < RXD) q.push_back(v);
      else ov = 1;
    end
    bus_read(16'h0000, d);
    tests++;
    if (d !== (32'h7 | (ov ? 32'h8 : 32'h0))) begin fails++; $display("FAIL ovr_set: csr=%h ovr_expected=%b", d, ov); end
    tests++;
    if (irq !== ov) begin fails++; $display("FAIL ovr_irq: irq=%b expected %b", irq, ov); end
    for (int i = 0; i < RXD + 1; i++) begin
      e = q.size() > 0 ? {24'h0, q.pop_front()} : 32'h0;
      bus_read(16'h0004, d);
      tests++;
      if (d !== e) begin fails++; $display("FAIL ovr_read %0d: data=%h expected %h", i, d, e); end
    end
    bus_write(16'h0000, 32'h8);
    bus_read(16'h0000, d);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL ovr_clear: csr=%h expected %h", d, 32'h5); end
  endtask
  task automatic test_reset_mid_frame;
    logic [31:0] d;
    bus_write(16'h0008, 32'd3);
    bus_write(16'h0004, 32'h0);
    tick(10);
    tests++;
    if (tx !== 1'b0) begin fails++; $display("FAIL midframe_low: tx=%b expected 0", tx); end
    reset = 1'b1;
    tick();
    tests++;
    if (tx !== 1'b1 || rdata !== 32'h0) begin fails++; $display("FAIL midframe_reset: tx=%b rdata=%h expected 1 0", tx, rdata); end
    reset = 1'b0;
    bus_read(16'h0000, d);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL midframe_csr: csr=%h expected %h", d, 32'h5); end
    bus_read(16'h0008, d);
    tests++;
    if (d !== 32'd434) begin fails++; $display("FAIL midframe_baud: baud=%0d expected 434", d); end
  endtask
  initial begin
    tick(3);
    reset = 1'b0;
    test_reset();
    test_tx_back_to_back();
    test_tx_overflow();
    test_tx_random();
    test_baud_clamp();
    test_rx();
    test_frame_err();
    test_irq_enables();
    test_overrun();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/per_uart_fifo.md
Name: per_uart_fifo

Overview:
- Full-duplex 8N1 UART peripheral on the peripheral bus; successor to the TX-only UART.
- Adds a receiver, parametrised TX/RX FIFOs, a runtime baud divisor register, sticky error flags and a maskable interrupt.
- Register read data is registered with one-cycle latency, matching the other peripherals.

Parameters:
TX_DEPTH, 16, TX FIFO entries; power of 2, 2..256
RX_DEPTH, 16, RX FIFO entries; power of 2, 2..256
DIV_WIDTH, 16, width of baud divisor register
DIV_RESET, 434, divisor reset value (115200 baud at 50 MHz)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
addr_i  in  16  register byte address
wdata_i  in  32  write data
rdata_o  out  32  read data, registered
size_i  in  2  access size; ignored, all registers word-wide
rd_i  in  1  read strobe, one cycle per access
wr_i  in  1  write strobe, one cycle per access
uart_rx_i  in  1  serial input, asynchronous
uart_tx_o  out  1  serial output, idle high
irq_o  out  1  interrupt, level, registered

Behaviour:
- Single clock domain; reset_i is synchronous and active-high. Reset values: uart_tx_o=1, rdata_o=0, irq_o=0. Both FIFOs are emptied, flags cleared, IRQ enables cleared, BAUD=DIV_RESET, TX and RX FSMs go IDLE.
- A reset mid-frame abandons the frame: uart_tx_o is high on the cycle after reset is sampled.
- Register map:
  - 0x0000 CSR:
    - bit0 TX_READY (TX FIFO not full)
    - bit1 RX_READY (RX FIFO not empty)
    - bit2 TX_IDLE (TX FIFO empty and TX FSM IDLE)
    - bit3 RX_OVERRUN, sticky, write-1-to-clear
    - bit4 FRAME_ERR, sticky, write-1-to-clear
    - bit8 IRQ_RX_EN, rw
    - bit9 IRQ_TX_EN, rw
    - other bits read 0
  - 0x0004 DATA: write pushes wdata_i[7:0] to the TX FIFO; the write is silently dropped if the FIFO is full. Read returns {24'h0, byte} and pops the RX FIFO; if the FIFO is empty the read returns 0 and nothing is popped.
  - 0x0008 BAUD: rw, DIV_WIDTH bits, zero-extended on read. The bit period is BAUD+1 clocks. A value below 2 is clamped to 2 internally.
  - Unmapped addresses read 0; writes to them are ignored.
- Read timing: rdata_o reflects the register state at the rd_i cycle and is valid on the next cycle. It holds its value until the next rd_i.
- A sticky flag set in the same cycle as a W1C write to it stays set (set wins).
- TX FSM (IDLE, START, DATA, STOP):
  - In IDLE with the FIFO non-empty: pop, latch the byte and BAUD, go to START. uart_tx_o goes low the cycle after the pop.
  - Each state lasts BAUD+1 clocks. DATA sends 8 bits, LSB first. STOP drives high.
  - At the end of STOP, if the FIFO is non-empty the next frame's START begins immediately with no idle gap; otherwise return to IDLE.
  - A BAUD write mid-frame takes effect at the next frame.
- RX path:
  - uart_rx_i passes through a 2-flop synchroniser (2-cycle latency).
  - RX FSM (IDLE, START, DATA, STOP): a falling edge in IDLE latches BAUD and enters START.
  - At BAUD/2 clocks (floor) the start bit is re-sampled; if high, it is a false start and the FSM returns to IDLE.
  - Each data bit is then sampled every BAUD+1 clocks, 8 bits, LSB first, followed by the stop bit sample.
  - Stop bit = 0: set FRAME_ERR, discard the byte.
  - Stop bit = 1 with FIFO full: set RX_OVERRUN, drop the new byte, keep existing contents.
  - Otherwise push the byte.
  - After the stop sample the FSM returns to IDLE and may detect the next start immediately.
- FIFOs: circular buffers with count registers.
  - Push and pop in the same cycle on a non-empty FIFO both succeed; the count is unchanged.
  - The full and empty flags are exact at depth boundaries, with pointers wrapping modulo depth.
- irq_o is registered, updated every cycle: (IRQ_RX_EN & RX_READY) | (IRQ_TX_EN & TX FIFO empty) | RX_OVERRUN | FRAME_ERR.

Test Plan:
- Reset, then read CSR at 0x0000 and BAUD at 0x0008 -> rdata_o 0x00000005 (TX_READY, TX_IDLE) and 434; uart_tx_o=1; irq_o=0.
- BAUD=3; write DATA 0x55 then 0xA3 -> uart_tx_o shows two back-to-back 40-clock frames, 4 clocks per bit, LSB first, no idle gap; TX_IDLE=1 after 80 clocks plus 1.
- TX_DEPTH=4, BAUD=3; write 6 bytes in consecutive cycles -> first popped immediately, next 4 stored, 6th dropped; 5 frames transmitted.
- BAUD=3; drive an RX frame 0x3C, then read DATA -> CSR RX_READY=1 after the stop sample; read returns 0x3C; RX_READY then 0. Repeat with a 1-clock low glitch -> false start, nothing pushed.
- RX frame with stop bit 0 -> FRAME_ERR=1, irq_o=1, FIFO empty. Write CSR 0x10 -> flag cleared, irq_o=0 one cycle later.
- RX_DEPTH=2; receive 3 frames without reading -> RX_OVERRUN=1; two reads return frames 1 and 2; a third read returns 0.
